// File: rtl/norm_arbiter.sv
// Arbitrates NUM_REQ operand sources onto one shared normalizer.
// Two-stage pipeline; NORM_ARB_ROUND_ROBIN_EN selects round-robin.
module norm_arbiter #(
  parameter  int DATA_WIDTH = 16,
  parameter  int TAG_WIDTH  = 2,
  localparam int NUM_REQ    = 2**TAG_WIDTH,
  localparam int UW         = DATA_WIDTH + 1,
  localparam int RW         = DATA_WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*UW-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [UW-1:0]        norm_unnorm,
  input  logic [RW-1:0]        norm_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RW-1:0]        out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  logic                 s1_valid_q, s1_valid_d;
  logic [UW-1:0]        s1_data_q, s1_data_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [RW-1:0]        s2_data_q, s2_data_d;
  logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

  logic                 grant_any;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic                 s1_load;
  logic                 s2_load;
  logic                 accept;
  logic [UW-1:0]        sel_data;

`ifdef NORM_ARB_ROUND_ROBIN_EN
  logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
  logic [TAG_WIDTH-1:0] idx;

  // Search valid requesters starting at the pointer, wrapping
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + TAG_WIDTH'(k);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Pointer moves past the winner only when it is accepted
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = grant_idx + TAG_WIDTH'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest valid index wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = TAG_WIDTH'(k);
      end
    end
  end
`endif

  assign grant = grant_any ?
                 (NUM_REQ'(1) << grant_idx) : '0;

  assign s2_load = s1_valid_q &&
                   (!s2_valid_q || out_ready);
  assign s1_load = !s1_valid_q || s2_load;
  assign accept  = grant_any && s1_load && !rst;

  assign req_ready = accept ? grant : '0;
  assign sel_data  = req_data[grant_idx*UW +: UW];

  // Stage advance; S1 operand cleared when empty
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    if (s1_load) begin
      s1_valid_d = accept;
      s1_data_d  = accept ? sel_data : '0;
      s1_tag_d   = accept ? grant_idx : '0;
    end
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = norm_result;
      s2_tag_d   = s1_tag_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign norm_unnorm = s1_data_q;
  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_tag     = s2_tag_q;
  assign busy        = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_norm_arbiter.sv
// Bench for norm_arbiter with a queue-based reference model.
// Stand-in normalizer is a fixed bit mapping.
module tb_norm_arbiter;

  localparam int NR = 4;
  localparam int UW = 17;
  localparam int RW = 15;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*UW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [UW-1:0]   norm_unnorm;
  logic [RW-1:0]   norm_result;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_data;
  logic [1:0]      out_tag;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]    tag;
    logic [UW-1:0] data;
  } item_t;

  item_t q[$];
  int    m_ptr   = 0;
  bit    m_fresh = 0;

  norm_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .norm_unnorm(norm_unnorm),
    .norm_result(norm_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  function automatic logic [RW-1:0] norm_fn(
    input logic [UW-1:0] u);
    return u[14:0] ^ 15'h4000 ^ {14'b0, u[16]};
  endfunction

  assign norm_result = norm_fn(norm_unnorm);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pred_grant(
    input logic [NR-1:0] v, input int ptr);
    int g;
    g = -1;
`ifdef NORM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NR; k++)
      if (g < 0 && v[(ptr + k) % NR]) g = (ptr + k) % NR;
`else
    for (int k = 0; k < NR; k++)
      if (g < 0 && v[k]) g = k;
`endif
    return g;
  endfunction

  // Two slots in flight; only a full pipe with a stalled sink blocks
  function automatic bit m_can_accept();
    return !(q.size() == 2 && !out_ready);
  endfunction

  function automatic bit m_out_valid();
    return q.size() == 2 || (q.size() == 1 && !m_fresh);
  endfunction

  function automatic logic [UW-1:0] m_unnorm();
    if (q.size() == 2 || (q.size() == 1 && m_fresh))
      return q[q.size()-1].data;
    return '0;
  endfunction

  function automatic logic [NR-1:0] m_ready();
    int g;
    g = pred_grant(req_valid, m_ptr);
    if (g >= 0 && m_can_accept() && !rst)
      return NR'(1) << g;
    return '0;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < NR; i++)
      req_data[i*UW +: UW] = UW'($urandom);
  endtask

  // Clock one edge and update the model; no comparisons here
  task automatic advance();
    int    g;
    bit    acc;
    bit    pop;
    item_t it;
    g   = pred_grant(req_valid, m_ptr);
    acc = (g >= 0) && m_can_accept() && !rst;
    pop = m_out_valid() && out_ready;
    if (acc) begin
      it.tag  = 2'(g);
      it.data = req_data[g*UW +: UW];
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ptr   = 0;
      m_fresh = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(it);
        m_ptr = (g + 1) % NR;
      end
      m_fresh = acc;
    end
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    rand_data();
    #1;
    n_checks++;
    if (req_ready !== 4'b0000)
      $display("FAIL reset_ready got %b want 0000", req_ready);
    else n_pass++;
    advance();
    advance();
    rst       = 1'b0;
    req_valid = '0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (out_data !== 15'h0 || out_tag !== 2'd0)
      $display("FAIL reset_out got %h/%0d want 0/0",
               out_data, out_tag);
    else n_pass++;
    n_checks++;
    if (norm_unnorm !== 17'h0)
      $display("FAIL reset_unnorm got %h want 0", norm_unnorm);
    else n_pass++;
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    out_ready = 1'b1;
    rand_data();
    req_data[2*UW +: UW] = 17'h0FC01;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100)
      $display("FAIL single_ready got %b want 0100", req_ready);
    else n_pass++;
    advance();
    req_valid = '0;
    rand_data();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || norm_unnorm !== 17'h0FC01)
      $display("FAIL single_s1 got %b/%h want 0/0fc01",
               out_valid, norm_unnorm);
    else n_pass++;
    advance();
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 2'd2 ||
        out_data !== 15'h3C01)
      $display("FAIL single_out got %b/%0d/%h want 1/2/3c01",
               out_valid, out_tag, out_data);
    else n_pass++;
    advance();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_drain got %b/%b want 0/0",
               out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic [NR-1:0] want;
    int            wtag;
    do_reset();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      #1;
`ifdef NORM_ARB_ROUND_ROBIN_EN
      want = NR'(1) << (k % NR);
      wtag = (k + NR - 2) % NR;
`else
      want = 4'b0001;
      wtag = 0;
`endif
      n_checks++;
      if (req_ready !== want)
        $display("FAIL fair_grant%0d got %b want %b",
                 k, req_ready, want);
      else n_pass++;
      if (k >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 2'(wtag) ||
            out_data !== norm_fn(q[0].data))
          $display("FAIL fair_out%0d got %b/%0d/%h want 1/%0d/%h",
                   k, out_valid, out_tag, out_data, wtag,
                   norm_fn(q[0].data));
        else n_pass++;
      end
      advance();
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) advance();
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] v;
    int            pops;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v = NR'(1) << $urandom_range(0, NR-1);
      req_valid = v;
      rand_data();
      #1;
      n_checks++;
      if (req_ready !== v)
        $display("FAIL bp_accept%0d got %b want %b",
                 k, req_ready, v);
      else n_pass++;
      advance();
    end
    out_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      #1;
      n_checks++;
      if (req_ready !== 4'b0000)
        $display("FAIL bp_ready%0d got %b want 0000",
                 k, req_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b1 || out_tag !== q[0].tag ||
          out_data !== norm_fn(q[0].data))
        $display("FAIL bp_hold%0d got %b/%0d/%h want 1/%0d/%h",
                 k, out_valid, out_tag, out_data,
                 q[0].tag, norm_fn(q[0].data));
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1 || norm_unnorm !== q[1].data)
        $display("FAIL bp_s1_%0d got %b/%h want 1/%h",
                 k, busy, norm_unnorm, q[1].data);
      else n_pass++;
      advance();
    end
    out_ready = 1'b1;
    req_valid = '0;
    pops = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid === 1'b1) begin
        pops++;
        n_checks++;
        if (q.size() == 0 || out_tag !== q[0].tag ||
            out_data !== norm_fn(q[0].data))
          $display("FAIL bp_drain%0d got %0d/%h unexpected",
                   k, out_tag, out_data);
        else n_pass++;
      end
      advance();
    end
    n_checks++;
    if (pops != 2)
      $display("FAIL bp_count got %0d want 2", pops);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [NR-1:0] w0, w1;
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    rand_data();
    advance();
    req_valid = 4'b1001;
`ifdef NORM_ARB_ROUND_ROBIN_EN
    w0 = 4'b1000;
    w1 = 4'b0001;
`else
    w0 = 4'b0001;
    w1 = 4'b0001;
`endif
    rand_data();
    #1;
    n_checks++;
    if (req_ready !== w0)
      $display("FAIL wrap_first got %b want %b", req_ready, w0);
    else n_pass++;
    advance();
    rand_data();
    #1;
    n_checks++;
    if (req_ready !== w1)
      $display("FAIL wrap_second got %b want %b", req_ready, w1);
    else n_pass++;
    advance();
    req_valid = '0;
    for (int k = 0; k < 3; k++) advance();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid = NR'(1) << $urandom_range(0, NR-1);
      rand_data();
      advance();
    end
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000)
      $display("FAIL mid_rst_ready got %b want 0000", req_ready);
    else n_pass++;
    advance();
    rst       = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 ||
          norm_unnorm !== 17'h0)
        $display("FAIL mid_empty%0d got %b/%b/%h want 0/0/0",
                 k, out_valid, busy, norm_unnorm);
      else n_pass++;
      advance();
    end
    req_valid = 4'b1111;
    rand_data();
    #1;
    n_checks++;
    if (req_ready !== 4'b0001)
      $display("FAIL mid_ptr got %b want 0001", req_ready);
    else n_pass++;
    advance();
    req_valid = '0;
  endtask

  task automatic test_idle();
    req_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) advance();
    for (int k = 0; k < 10; k++) begin
      rand_data();
      out_ready = 1'($urandom);
      #1;
      n_checks++;
      if (norm_unnorm !== 17'h0 || out_valid !== 1'b0 ||
          busy !== 1'b0)
        $display("FAIL idle%0d got %h/%b/%b want 0/0/0",
                 k, norm_unnorm, out_valid, busy);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] want;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = NR'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_data();
      #1;
      want = m_ready();
      n_checks++;
      if (req_ready !== want)
        $display("FAIL rnd_ready c%0d got %b want %b",
                 c, req_ready, want);
      else n_pass++;
      n_checks++;
      if (out_valid !== m_out_valid())
        $display("FAIL rnd_valid c%0d got %b want %b",
                 c, out_valid, m_out_valid());
      else n_pass++;
      n_checks++;
      if (busy !== (q.size() != 0))
        $display("FAIL rnd_busy c%0d got %b want %b",
                 c, busy, q.size() != 0);
      else n_pass++;
      n_checks++;
      if (norm_unnorm !== m_unnorm())
        $display("FAIL rnd_unnorm c%0d got %h want %h",
                 c, norm_unnorm, m_unnorm());
      else n_pass++;
      if (m_out_valid()) begin
        n_checks++;
        if (out_tag !== q[0].tag ||
            out_data !== norm_fn(q[0].data))
          $display("FAIL rnd_out c%0d got %0d/%h want %0d/%h",
                   c, out_tag, out_data, q[0].tag,
                   norm_fn(q[0].data));
        else n_pass++;
      end
      advance();
    end
    rst       = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
